// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback slice: branch condition codes,
// status bit positions and the buffered entry layout.
package alu_pkg;

   typedef enum logic [2:0] {
      EQ     = 3'd0,
      NE     = 3'd1,
      ALWAYS = 3'd2,
      LT     = 3'd4,
      GE     = 3'd5
   } br_cond_e;

   localparam int STAT_Z = 0;
   localparam int STAT_V = 1;
   localparam int STAT_N = 2;

   // Control/status part of a buffered entry. The XLEN-wide result is
   // concatenated alongside it by the stage, since a package type cannot
   // follow the stage's XLEN parameter.
   typedef struct packed {
      logic [2:0] status;     // {N,V,Z}
      logic [4:0] rd;
      logic       rd_we;
      logic       is_branch;
      logic [2:0] br_cond;
      logic       set_flags;
   } wb_entry_t;

   // Branch resolution against the entry's own captured status.
   // Undefined condition codes resolve to not-taken.
   function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] st);
      logic res;
      res = 1'b0;
      case (cond)
         EQ:      res = st[STAT_Z];
         NE:      res = !st[STAT_Z];
         ALWAYS:  res = 1'b1;
         LT:      res = st[STAT_N] ^ st[STAT_V];
         GE:      res = !(st[STAT_N] ^ st[STAT_V]);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small synchronous FIFO holding writeback entries. Push into a full FIFO
// and pop from an empty one are ignored; flush empties it on the next edge
// and wins over a same-cycle push.
module wb_skid_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok, pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are qualified by count so no reset is needed
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback stage: buffers ALU results, resolves branches on the
// head entry, drives the register-file write port and keeps the
// architectural {N,V,Z} flags.
// Optional performance counters are built when ALU_WB_PERF_EN is defined.
module alu_writeback_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] alu_out,
   input  logic [2:0]      alu_status,
   input  logic [4:0]      rd_addr,
   input  logic            rd_we,
   input  logic            is_branch,
   input  logic [2:0]      br_cond,
   input  logic            set_flags,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_we,
   output logic            branch_taken,
   output logic [2:0]      flags_q,
   output logic [31:0]     perf_taken,
   output logic [31:0]     perf_stall
);

   localparam int EW = XLEN + $bits(wb_entry_t);

   wb_entry_t       in_ent, head;
   logic [XLEN-1:0] head_data, hold_data;
   logic [4:0]      hold_rd;
   logic            full, empty, push, pop;

   // Pack the incoming instruction's control/status fields
   always_comb begin
      in_ent           = '0;
      in_ent.status    = alu_status;
      in_ent.rd        = rd_addr;
      in_ent.rd_we     = rd_we;
      in_ent.is_branch = is_branch;
      in_ent.br_cond   = br_cond;
      in_ent.set_flags = set_flags;
   end

   wb_skid_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   ({alu_out, in_ent}),
      .dout  ({head_data, head}),
      .full  (full),
      .empty (empty)
   );

   // in_ready comes straight from the registered occupancy
   assign in_ready     = !full;
   assign out_valid    = !empty;
   assign push         = in_valid && in_ready && !flush;
   assign pop          = out_valid && out_ready;
   assign branch_taken = out_valid && head.is_branch && cond_true(head.br_cond, head.status);
   assign wb_we        = out_valid && head.rd_we && (head.rd != 5'd0) && !head.is_branch;
   assign wb_data      = out_valid ? head_data : hold_data;
   assign wb_rd        = out_valid ? head.rd   : hold_rd;

   // Remember the last retired result so the port holds steady while empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_data <= '0;
         hold_rd   <= '0;
      end else if (pop) begin
         hold_data <= head_data;
         hold_rd   <= head.rd;
      end
   end

   // Architectural flags update on retirement; a retirement racing a flush is discarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             flags_q <= 3'b000;
      else if (pop && !flush && head.set_flags) flags_q <= head.status;
   end

`ifdef ALU_WB_PERF_EN
   // Saturating taken-branch and input-stall counters; only reset clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_taken <= '0;
         perf_stall <= '0;
      end else begin
         if (pop && branch_taken && (perf_taken != 32'hFFFF_FFFF))
            perf_taken <= perf_taken + 32'd1;
         if (in_valid && !in_ready && (perf_stall != 32'hFFFF_FFFF))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`else
   assign perf_taken = '0;
   assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage (DEPTH=2, XLEN=32).
module tb_alu_writeback_stage;

   logic        clk, rst_n, flush, in_valid, in_ready;
   logic [31:0] alu_out;
   logic [2:0]  alu_status;
   logic [4:0]  rd_addr;
   logic        rd_we, is_branch, set_flags;
   logic [2:0]  br_cond;
   logic        out_valid, out_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_we, branch_taken;
   logic [2:0]  flags_q;
   logic [31:0] perf_taken, perf_stall;

   int n_assert = 0;
   int n_fail   = 0;

   alu_writeback_stage #(.DEPTH(2), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .alu_status(alu_status), .rd_addr(rd_addr), .rd_we(rd_we),
      .is_branch(is_branch), .br_cond(br_cond), .set_flags(set_flags),
      .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_we(wb_we), .branch_taken(branch_taken), .flags_q(flags_q),
      .perf_taken(perf_taken), .perf_stall(perf_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single accepting edge
   task automatic send(input logic [31:0] d, input logic [2:0] st, input logic [4:0] rd,
                       input logic we, input logic br, input logic [2:0] cond, input logic sf);
      alu_out = d; alu_status = st; rd_addr = rd; rd_we = we;
      is_branch = br; br_cond = cond; set_flags = sf; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_out = '0; alu_status = '0;
      rd_addr = '0; rd_we = 1'b0; is_branch = 1'b0; br_cond = '0; set_flags = 1'b0;
      out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_flags", 32'(flags_q), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_branch", 32'(branch_taken), 32'd0);
      chk("rst_perf_taken", perf_taken, 32'd0);
      chk("rst_perf_stall", perf_stall, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Single push, visible next cycle, gone the cycle after
      send(32'h5, 3'b000, 5'd3, 1'b1, 1'b0, 3'd0, 1'b0);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_wb_data", wb_data, 32'h5);
      chk("t1_wb_rd", 32'(wb_rd), 32'd3);
      chk("t1_wb_we", 32'(wb_we), 32'd1);
      tick();
      chk("t1_empty", 32'(out_valid), 32'd0);
      chk("t1_hold_data", wb_data, 32'h5);
      chk("t1_empty_we", 32'(wb_we), 32'd0);

      // x0 destination suppresses the write
      send(32'h7, 3'b000, 5'd0, 1'b1, 1'b0, 3'd0, 1'b0);
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_wb_we_x0", 32'(wb_we), 32'd0);
      tick();

      // Branch resolution
      send(32'h0, 3'b100, 5'd5, 1'b1, 1'b1, 3'd4, 1'b0);
      chk("t3_lt_n", 32'(branch_taken), 32'd1);
      chk("t3_br_no_we", 32'(wb_we), 32'd0);
      tick();
      chk("t3_empty_br", 32'(branch_taken), 32'd0);
      send(32'h0, 3'b110, 5'd0, 1'b0, 1'b1, 3'd4, 1'b0);
      chk("t3_lt_nv", 32'(branch_taken), 32'd0);
      tick();
      send(32'h0, 3'b001, 5'd0, 1'b0, 1'b1, 3'd0, 1'b0);
      chk("t3_eq_z", 32'(branch_taken), 32'd1);
      tick();
      send(32'h0, 3'b001, 5'd0, 1'b0, 1'b1, 3'd1, 1'b0);
      chk("t3_ne_z", 32'(branch_taken), 32'd0);
      tick();
      send(32'h0, 3'b000, 5'd0, 1'b0, 1'b1, 3'd3, 1'b0);
      chk("t3_undef_cond", 32'(branch_taken), 32'd0);
      tick();
      send(32'h0, 3'b000, 5'd0, 1'b0, 1'b1, 3'd2, 1'b0);
      chk("t3_always", 32'(branch_taken), 32'd1);
      tick();
      send(32'h0, 3'b110, 5'd0, 1'b0, 1'b1, 3'd5, 1'b0);
      chk("t3_ge_nv", 32'(branch_taken), 32'd1);
      tick();
`ifdef ALU_WB_PERF_EN
      chk("t3_perf_taken", perf_taken, 32'd4);
`else
      chk("t3_perf_taken", perf_taken, 32'd0);
`endif

      // Backpressure: fill, stall the third, drain in order
      out_ready = 1'b0;
      send(32'h1, 3'b000, 5'd1, 1'b1, 1'b0, 3'd0, 1'b0);
      chk("t4_ready_one", 32'(in_ready), 32'd1);
      send(32'h2, 3'b000, 5'd2, 1'b1, 1'b0, 3'd0, 1'b0);
      chk("t4_full", 32'(in_ready), 32'd0);
      alu_out = 32'h3; rd_addr = 5'd3; in_valid = 1'b1;
      tick(); tick(); tick();
      chk("t4_still_full", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      chk("t4_head1", wb_data, 32'h1);
      tick();
      chk("t4_head2", wb_data, 32'h2);
      chk("t4_ready_again", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t4_head3", wb_data, 32'h3);
      tick();
      chk("t4_drained", 32'(out_valid), 32'd0);
`ifdef ALU_WB_PERF_EN
      chk("t4_perf_stall", perf_stall, 32'd4);
`else
      chk("t4_perf_stall", perf_stall, 32'd0);
`endif

      // Flag register
      send(32'h0, 3'b011, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1);
      chk("t5_flags_pre", 32'(flags_q), 32'd0);
      tick();
      chk("t5_flags_set", 32'(flags_q), 32'b011);
      send(32'h0, 3'b100, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
      tick();
      chk("t5_flags_hold", 32'(flags_q), 32'b011);

      // Flush with two buffered entries and a same-cycle push and pop
      out_ready = 1'b0;
      send(32'hA, 3'b101, 5'd4, 1'b1, 1'b0, 3'd0, 1'b1);
      send(32'hB, 3'b101, 5'd4, 1'b1, 1'b0, 3'd0, 1'b1);
      chk("t6_full", 32'(in_ready), 32'd0);
      flush = 1'b1; in_valid = 1'b1; alu_out = 32'hDEAD; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_in_ready", 32'(in_ready), 32'd1);
      chk("t6_flags", 32'(flags_q), 32'b011);
      // Flush with room available: the same-cycle push must be dropped
      out_ready = 1'b0;
      send(32'hC, 3'b000, 5'd6, 1'b1, 1'b0, 3'd0, 1'b0);
      flush = 1'b1; in_valid = 1'b1; alu_out = 32'hBEEF;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("t6_dropped", 32'(out_valid), 32'd0);
      tick();
      chk("t6_dropped_late", 32'(out_valid), 32'd0);
      chk("t6_no_we", 32'(wb_we), 32'd0);

      // Asynchronous reset mid-operation
      send(32'h9, 3'b000, 5'd9, 1'b1, 1'b0, 3'd0, 1'b0);
      chk("t7_pre", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_async_valid", 32'(out_valid), 32'd0);
      chk("t7_async_flags", 32'(flags_q), 32'd0);
      chk("t7_async_data", wb_data, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("t7_ready", 32'(in_ready), 32'd1);
      chk("t7_perf_clear", perf_stall, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute-to-writeback stage directly downstream of the ALU.
- Captures ALU result, status {N,V,Z}, destination register and branch info into a small registered buffer with valid/ready handshake.
- Resolves branch conditions from the captured status and maintains an architectural flag register.
- Drives register-file write port and branch-taken signal to fetch.

Parameters:
DEPTH, 2, buffer entries (power of two, >=2)
XLEN, 32, data width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept (registered, = !full)
alu_out  input  XLEN  ALU result
alu_status  input  3  {NEGATIVE, OVERFLOW, ZERO} from ALU
rd_addr  input  5  destination register
rd_we  input  1  instruction writes rd
is_branch  input  1  instruction is a conditional branch
br_cond  input  3  branch condition code
set_flags  input  1  update flag register when retired
out_valid  output  1  head entry valid
out_ready  input  1  writeback/fetch consumes head
wb_data  output  XLEN  head result
wb_rd  output  5  head destination
wb_we  output  1  out_valid & rd_we & (rd != 0) & !is_branch
branch_taken  output  1  out_valid & is_branch & cond_true (head)
flags_q  output  3  architectural {N,V,Z}
perf_taken  output  32  taken-branch count (see Optional Feature)
perf_stall  output  32  input-stall cycle count (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): buffer empty, out_valid=0, in_ready=1 after release, flags_q=3'b000, wb_*=0, branch_taken=0, counters=0.
- Push on in_valid & in_ready; pop on out_valid & out_ready. Entry = {alu_out, alu_status, rd_addr, rd_we, is_branch, br_cond, set_flags}.
- Latency: data accepted in cycle t appears on outputs at t+1 when buffer empty; FIFO order preserved.
- Simultaneous push and pop: both occur, occupancy unchanged. Full: in_ready=0, no push even if pop occurs that cycle (ready is registered from count).
- Empty: out_valid=0; wb_we and branch_taken forced 0; wb_data/wb_rd hold last value.
- Pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
- Condition codes (on head entry's own status): 0 EQ: Z; 1 NE: !Z; 4 LT: N^V; 5 GE: !(N^V); 2 ALWAYS: 1; others: 0 (not taken).
- Flags: on pop with set_flags=1, flags_q <= entry status next cycle; otherwise hold.
- flush: next edge empties buffer; a push in the same cycle is dropped; a pop in the same cycle does not update flags_q; flags_q otherwise retained.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro ALU_WB_PERF_EN.
- Defined: perf_taken increments on every pop with branch_taken=1; perf_stall increments each cycle in_valid=1 & in_ready=0; both saturate at 32'hFFFF_FFFF and clear only on reset (flush does not clear).
- Not defined: counters are not built; perf_taken and perf_stall tie to 0.

Decomposition:
- Shared package alu_pkg: br_cond_e enum (EQ=0, NE=1, ALWAYS=2, LT=4, GE=5), status bit indices (STAT_Z=0, STAT_V=1, STAT_N=2), wb_entry_t packed struct.
- ALUop codes remain in defines.sv.
- One sub-module: wb_skid_fifo (parameterised DEPTH, width of wb_entry_t; push/pop/full/empty/flush).
- Condition evaluation and counters stay inline.

Test Plan:
- Reset then single push alu_out=32'h0000_0005, rd=3, rd_we=1, out_ready=1 -> next cycle out_valid=1, wb_data=5, wb_rd=3, wb_we=1; following cycle out_valid=0.
- rd_addr=0 with rd_we=1 -> wb_we=0 while out_valid=1.
- Branch LT with status 3'b100 (N=1, V=0) -> branch_taken=1; status 3'b110 -> branch_taken=0; EQ with status 3'b001 -> taken.
- out_ready=0, push 3 entries (DEPTH=2) -> in_ready=0 after second; third held by source; release out_ready -> data pops in order 1,2,3 with no loss; with macro, perf_stall equals stall cycle count.
- set_flags=1 entry with status 3'b011 popped -> flags_q=3'b011 next cycle; subsequent set_flags=0 pop -> flags_q unchanged.
- Two entries buffered, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flags_q unchanged, dropped input never appears.
